// File: rtl/instruction_fetch_pkg.sv
// Shared fetch definitions: width defaults, reset vector, FSM encodings.
// Consumed by instruction_fetch and its return stack (FETCH_RETURN_STACK_EN).
package instruction_fetch_pkg;

    localparam int ADDR_WIDTH_DEF   = 16;
    localparam int DATA_WIDTH_DEF   = 16;
    localparam int RESET_VECTOR_DEF = 0;
    localparam int RAS_DEPTH_DEF    = 4;

    typedef enum logic {
        FETCH_RUN    = 1'b0,
        FETCH_HALTED = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_return_stack.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
// Only built when FETCH_RETURN_STACK_EN is defined.
`ifdef FETCH_RETURN_STACK_EN
module instruction_fetch_return_stack #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_top;
    logic [CW-1:0]    r_count;
    logic [PW-1:0]    w_top_next;
    logic [PW-1:0]    w_top_prev;
    logic             w_full;

    assign w_top_next = (r_top == PW'(DEPTH - 1)) ? '0 : r_top + PW'(1);
    assign w_top_prev = (r_top == '0) ? PW'(DEPTH - 1) : r_top - PW'(1);
    assign w_full     = (r_count == CW'(DEPTH));
    assign empty      = (r_count == '0);
    assign pop_data   = r_mem[w_top_prev];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_top   <= '0;
            r_count <= '0;
        end else if (push) begin
            r_top <= w_top_next;
            if (!w_full) r_count <= r_count + CW'(1);
        end else if (pop && !empty) begin
            r_top   <= w_top_prev;
            r_count <= r_count - CW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (push) r_mem[r_top] <= push_data;
    end

endmodule
`endif

// File: rtl/instruction_fetch.sv
// PC sequencer with 1-entry skid over a 1-cycle memory, redirect and halt.
// FETCH_RETURN_STACK_EN adds call/ret ports backed by a return stack.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = ADDR_WIDTH'(RESET_VECTOR_DEF),
    parameter int RAS_DEPTH  = RAS_DEPTH_DEF
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic [ADDR_WIDTH-1:0] program_counter,
    input  logic [DATA_WIDTH-1:0] mem_instruction,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_instruction,
    output logic [ADDR_WIDTH-1:0] out_pc,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_target,
`ifdef FETCH_RETURN_STACK_EN
    input  logic                  call_valid,
    input  logic [ADDR_WIDTH-1:0] call_target,
    input  logic                  ret_valid,
    output logic                  ras_underflow,
`endif
    input  logic                  halt_req,
    output logic                  halted
);

    logic [ADDR_WIDTH-1:0] r_pc;
    logic [ADDR_WIDTH-1:0] r_resp_pc;
    logic                  r_resp_valid;
    logic [ADDR_WIDTH-1:0] r_skid_pc;
    logic [DATA_WIDTH-1:0] r_skid_instr;
    logic                  r_skid_valid;
    fetch_state_e          r_state;
    fetch_state_e          w_state_next;
    logic                  w_redirect;
    logic [ADDR_WIDTH-1:0] w_target;
    logic                  w_issue;

`ifdef FETCH_RETURN_STACK_EN
    logic                  w_call;
    logic                  w_ret;
    logic                  w_ras_empty;
    logic [ADDR_WIDTH-1:0] w_ras_top;
    logic                  r_ras_underflow;

    assign w_call = call_valid & ~redirect_valid;
    assign w_ret  = ret_valid & ~redirect_valid & ~call_valid;

    instruction_fetch_return_stack #(
        .DEPTH (RAS_DEPTH),
        .WIDTH (ADDR_WIDTH)
    ) u_ras (
        .clock     (clock),
        .reset     (reset),
        .push      (w_call),
        .pop       (w_ret),
        .push_data (out_pc + ADDR_WIDTH'(1)),
        .pop_data  (w_ras_top),
        .empty     (w_ras_empty)
    );

    assign w_redirect = redirect_valid | call_valid | ret_valid;
    assign w_target   = redirect_valid ? redirect_target :
                        call_valid     ? call_target     :
                        w_ras_empty    ? RESET_VECTOR    : w_ras_top;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_ras_underflow <= 1'b0;
        else       r_ras_underflow <= w_ret & w_ras_empty;
    end

    assign ras_underflow = r_ras_underflow;
`else
    assign w_redirect = redirect_valid;
    assign w_target   = redirect_target;
`endif

    // A held response or a full skid blocks the next request.
    assign w_issue = (r_state == FETCH_RUN) & ~r_skid_valid
                   & ~(r_resp_valid & ~out_ready) & ~w_redirect;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            FETCH_RUN:    if (halt_req && !w_redirect) w_state_next = FETCH_HALTED;
            FETCH_HALTED: if (w_redirect) w_state_next = FETCH_RUN;
            default:      w_state_next = FETCH_RUN;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= FETCH_RUN;
            r_pc         <= RESET_VECTOR;
            r_resp_pc    <= RESET_VECTOR;
            r_resp_valid <= 1'b0;
            r_skid_pc    <= RESET_VECTOR;
            r_skid_instr <= '0;
            r_skid_valid <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_redirect) begin
                r_pc         <= w_target;
                r_resp_valid <= 1'b0;
                r_skid_valid <= 1'b0;
            end else begin
                r_resp_valid <= w_issue;
                if (w_issue) begin
                    r_resp_pc <= r_pc;
                    r_pc      <= r_pc + ADDR_WIDTH'(1);
                end
                // Memory data lives one cycle only, so a stalled response moves to the skid.
                if (r_skid_valid && out_ready) begin
                    r_skid_valid <= 1'b0;
                end else if (r_resp_valid && !out_ready && !r_skid_valid) begin
                    r_skid_valid <= 1'b1;
                    r_skid_pc    <= r_resp_pc;
                    r_skid_instr <= mem_instruction;
                end
            end
        end
    end

    assign program_counter = r_pc;
    assign out_valid       = r_skid_valid | r_resp_valid;
    assign out_instruction = r_skid_valid ? r_skid_instr : mem_instruction;
    assign out_pc          = r_skid_valid ? r_skid_pc : r_resp_pc;
    assign halted          = (r_state == FETCH_HALTED);

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench: expected PC stream queued by the driver, popped by a monitor.
module tb_instruction_fetch;

    logic        clock;
    logic        reset;
    logic [15:0] program_counter;
    logic [15:0] mem_instruction;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_instruction;
    logic [15:0] out_pc;
    logic        redirect_valid;
    logic [15:0] redirect_target;
    logic        halt_req;
    logic        halted;
`ifdef FETCH_RETURN_STACK_EN
    logic        call_valid;
    logic [15:0] call_target;
    logic        ret_valid;
    logic        ras_underflow;
`endif

    instruction_fetch dut (
        .clock           (clock),
        .reset           (reset),
        .program_counter (program_counter),
        .mem_instruction (mem_instruction),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_instruction (out_instruction),
        .out_pc          (out_pc),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
`ifdef FETCH_RETURN_STACK_EN
        .call_valid      (call_valid),
        .call_target     (call_target),
        .ret_valid       (ret_valid),
        .ras_underflow   (ras_underflow),
`endif
        .halt_req        (halt_req),
        .halted          (halted)
    );

    int n_checks = 0;
    int n_errors = 0;
    int n_acc    = 0;
    logic [15:0] exp_q[$];

    function automatic logic [15:0] memf(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'hC3A5;
    endfunction

    task automatic chk(input string name, input logic ok,
                       input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    // Expected delivery order after a (re)start at t: t, t+1, ... mod 2^16.
    task automatic restart(input logic [15:0] t);
        exp_q.delete();
        for (int i = 0; i < 256; i++) exp_q.push_back(16'(t + 16'(i)));
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) mem_instruction <= memf(program_counter);

    logic        stall_prev = 1'b0;
    logic [15:0] prev_pc;
    logic [15:0] prev_ins;
    logic [15:0] e;

    always @(negedge clock) begin
        if (reset) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev)
                chk("stall_hold", out_valid && out_pc == prev_pc && out_instruction == prev_ins,
                    {out_pc, out_instruction}, {prev_pc, prev_ins});
            if (out_valid && out_ready && !redirect_valid) begin
                n_acc++;
                if (exp_q.size() == 0) begin
                    chk("sb_extra", 1'b0, {16'h0, out_pc}, 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_pc", out_pc == e, {16'h0, out_pc}, {16'h0, e});
                    chk("sb_instr", out_instruction == memf(e),
                        {16'h0, out_instruction}, {16'h0, memf(e)});
                end
            end
            stall_prev = out_valid && !out_ready && !redirect_valid;
            prev_pc    = out_pc;
            prev_ins   = out_instruction;
        end
    end

    logic [15:0] hold_pc;
    logic [15:0] hold_ins;
    logic [15:0] halt_pc;
    int          seg;
    int          hcnt;

    initial begin
        reset           = 1'b1;
        out_ready       = 1'b1;
        redirect_valid  = 1'b0;
        redirect_target = '0;
        halt_req        = 1'b0;
`ifdef FETCH_RETURN_STACK_EN
        call_valid  = 1'b0;
        call_target = '0;
        ret_valid   = 1'b0;
`endif
        repeat (3) step();
        chk("rst_valid", out_valid == 1'b0, {31'h0, out_valid}, 32'h0);
        chk("rst_halted", halted == 1'b0, {31'h0, halted}, 32'h0);
        chk("rst_pc", program_counter == 16'h0, {16'h0, program_counter}, 32'h0);

        restart(16'h0000);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("t1_pc", out_valid && out_pc == 16'(k), {15'h0, out_valid, out_pc}, {15'h0, 1'b1, 16'(k)});
        end

        out_ready = 1'b0;
        hold_pc   = out_pc;
        hold_ins  = out_instruction;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("t2_hold", out_valid && out_pc == hold_pc && out_instruction == hold_ins,
                {out_pc, out_instruction}, {hold_pc, hold_ins});
        end
        out_ready = 1'b1;
        repeat (3) step();

        out_ready = 1'b0;
        step();
        step();
        chk("t3_skid_full", out_valid == 1'b1, {31'h0, out_valid}, 32'h1);
        redirect_valid  = 1'b1;
        redirect_target = 16'h0100;
        restart(16'h0100);
        step();
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        chk("t3_flushed", out_valid == 1'b0, {31'h0, out_valid}, 32'h0);
        step();
        chk("t3_target", out_valid && out_pc == 16'h0100, {15'h0, out_valid, out_pc}, {15'h0, 1'b1, 16'h0100});

        redirect_valid  = 1'b1;
        redirect_target = 16'hFFFE;
        restart(16'hFFFE);
        step();
        redirect_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("t4_wrap", out_valid && out_pc == 16'(16'hFFFE + 16'(k)),
                {16'h0, out_pc}, {16'h0, 16'(16'hFFFE + 16'(k))});
        end

        redirect_valid  = 1'b1;
        redirect_target = 16'h0005;
        restart(16'h0005);
        step();
        redirect_valid = 1'b0;
        halt_req       = 1'b1;
        chk("t5_pc5", program_counter == 16'h0005, {16'h0, program_counter}, 32'h5);
        step();
        halt_req = 1'b0;
        chk("t5_halted", halted == 1'b1, {31'h0, halted}, 32'h1);
        repeat (3) step();
        chk("t5_drained", out_valid == 1'b0, {31'h0, out_valid}, 32'h0);
        chk("t5_pc_stop", program_counter == 16'h0006, {16'h0, program_counter}, 32'h6);
        chk("t5_no_loss", exp_q.size() > 0 && exp_q[0] == program_counter,
            {16'h0, program_counter}, {16'h0, (exp_q.size() > 0) ? exp_q[0] : 16'hxxxx});
        halt_pc = program_counter;
        repeat (2) step();
        chk("t5_pc_hold", program_counter == halt_pc && halted, {16'h0, program_counter}, {16'h0, halt_pc});
        redirect_valid  = 1'b1;
        redirect_target = 16'h0020;
        restart(16'h0020);
        step();
        redirect_valid = 1'b0;
        chk("t5_resume", halted == 1'b0, {31'h0, halted}, 32'h0);
        step();
        chk("t5_target", out_valid && out_pc == 16'h0020, {15'h0, out_valid, out_pc}, {15'h0, 1'b1, 16'h0020});

        seg  = 0;
        hcnt = 0;
        for (int c = 0; c < 3000; c++) begin
            halt_req       = 1'b0;
            redirect_valid = 1'b0;
            hcnt = halted ? hcnt + 1 : 0;
            if ($urandom_range(0, 499) == 0) begin
                reset = 1'b1;
                restart(16'h0000);
                #1;
                chk("rst_mid", !out_valid && program_counter == 16'h0000,
                    {15'h0, out_valid, program_counter}, 32'h0);
                step();
                reset = 1'b0;
                seg   = 0;
                continue;
            end
            out_ready = ($urandom_range(0, 9) < 7);
            if (seg > 150 || hcnt > 4 || $urandom_range(0, 39) == 0) begin
                redirect_valid  = 1'b1;
                redirect_target = ($urandom_range(0, 1) == 0) ? 16'($urandom)
                                : 16'($urandom_range(16'hFFF0, 16'hFFFF));
                restart(redirect_target);
                seg = 0;
            end else if ($urandom_range(0, 59) == 0) begin
                halt_req = 1'b1;
            end
            step();
            seg++;
        end

        chk("acc_count", n_acc > 1000, n_acc, 32'd1000);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
